// File: rtl/aes_frame_assembler_if.sv
// Signal bundle between the SPI byte front end, the frame assembler and the AES core.
// Handshakes: rx_valid, core_start, core_done and err are single-cycle strobes with no
// back-pressure; a tx byte moves on every rising edge where tx_valid && tx_ready are both
// high, and tx_byte stays stable while tx_valid is high and tx_ready is low.
interface aes_frame_assembler_if;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic [127:0] text_out;
  logic [127:0] key_out;
  logic         core_start;
  logic         core_busy;
  logic         core_done;
  logic [127:0] core_result;
  logic         tx_valid;
  logic [7:0]   tx_byte;
  logic         tx_ready;
  logic         text_loaded;
  logic         key_loaded;
  logic         result_ready;
  logic         err;

  modport slave (
    input  rx_valid, rx_byte, core_busy, core_done, core_result, tx_ready,
    output text_out, key_out, core_start, tx_valid, tx_byte,
           text_loaded, key_loaded, result_ready, err
  );

  modport master (
    output rx_valid, rx_byte, core_busy, core_done, core_result, tx_ready,
    input  text_out, key_out, core_start, tx_valid, tx_byte,
           text_loaded, key_loaded, result_ready, err
  );
endinterface

// File: rtl/aes_frame_assembler.sv
// Parses SPI command frames into 128-bit text/key blocks, launches the AES core and
// streams the result back MSB first. Optional inter-byte timeout: FRAME_TIMEOUT_EN.
module aes_frame_assembler #(
  parameter logic [7:0] CMD_TEXT  = 8'h01,
  parameter logic [7:0] CMD_KEY   = 8'h02,
  parameter logic [7:0] CMD_START = 8'h03,
  parameter logic [7:0] CMD_READ  = 8'h04
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  aes_frame_assembler_if.slave         bus,
  output logic [2:0]                   o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RX_TEXT   = 3'd1,
    S_RX_KEY    = 3'd2,
    S_LAUNCH    = 3'd3,
    S_WAIT_CORE = 3'd4,
    S_TX_RESULT = 3'd5
  } state_t;

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_shadow;
  logic [127:0] r_text;
  logic [127:0] r_key;
  logic [127:0] r_result;
  logic         r_text_loaded;
  logic         r_key_loaded;
  logic         r_result_ready;
  logic         r_err;
  logic         r_core_start;

  logic w_shift, w_commit_text, w_commit_key, w_abort;
  logic w_launch, w_capture, w_tx_shift, w_tx_last, w_err;
  logic w_tx_valid;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_timer;
  logic          w_timeout;
  logic          w_in_rx;

  assign w_in_rx   = (r_state == S_RX_TEXT) || (r_state == S_RX_KEY);
  assign w_timeout = w_in_rx && !bus.rx_valid && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // Counts consecutive cycles without a byte while a frame is open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
    end else if (w_in_rx && !bus.rx_valid && !w_timeout) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift       = 1'b0;
    w_commit_text = 1'b0;
    w_commit_key  = 1'b0;
    w_abort       = 1'b0;
    w_launch      = 1'b0;
    w_capture     = 1'b0;
    w_tx_shift    = 1'b0;
    w_tx_last     = 1'b0;
    w_err         = 1'b0;
    w_tx_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_byte == CMD_TEXT) begin
            w_state_nxt = S_RX_TEXT;
          end else if (bus.rx_byte == CMD_KEY) begin
            w_state_nxt = S_RX_KEY;
          end else if (bus.rx_byte == CMD_START) begin
            if (r_text_loaded && r_key_loaded) w_state_nxt = S_LAUNCH;
            else                               w_err       = 1'b1;
          end else if (bus.rx_byte == CMD_READ) begin
            if (r_result_ready) w_state_nxt = S_TX_RESULT;
            else                w_err       = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_RX_TEXT, S_RX_KEY: begin
        if (bus.rx_valid) begin
          w_shift = 1'b1;
          if (r_cnt == 4'd15) begin
            w_commit_text = (r_state == S_RX_TEXT);
            w_commit_key  = (r_state == S_RX_KEY);
            w_state_nxt   = S_IDLE;
          end
        end
`ifdef FRAME_TIMEOUT_EN
        else if (w_timeout) begin
          w_abort     = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
`endif
      end
      S_LAUNCH: begin
        if (!bus.core_busy) begin
          w_launch    = 1'b1;
          w_state_nxt = S_WAIT_CORE;
        end
      end
      S_WAIT_CORE: begin
        // A byte arriving while the core works is lost; flag it even if done coincides.
        if (bus.rx_valid) w_err = 1'b1;
        if (bus.core_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_TX_RESULT: begin
        w_tx_valid = 1'b1;
        if (bus.tx_ready) begin
          w_tx_shift = 1'b1;
          if (r_cnt == 4'd15) begin
            w_tx_last   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt          <= 4'd0;
      r_shadow       <= '0;
      r_text         <= '0;
      r_key          <= '0;
      r_result       <= '0;
      r_text_loaded  <= 1'b0;
      r_key_loaded   <= 1'b0;
      r_result_ready <= 1'b0;
      r_err          <= 1'b0;
      r_core_start   <= 1'b0;
    end else begin
      r_err        <= w_err;
      r_core_start <= w_launch;

      if (w_commit_text || w_commit_key || w_abort || w_tx_last) r_cnt <= 4'd0;
      else if (w_shift || w_tx_shift)                            r_cnt <= r_cnt + 4'd1;

      if (w_abort)      r_shadow <= '0;
      else if (w_shift) r_shadow <= {r_shadow[119:0], bus.rx_byte};

      if (w_commit_text) begin
        r_text        <= {r_shadow[119:0], bus.rx_byte};
        r_text_loaded <= 1'b1;
      end
      if (w_commit_key) begin
        r_key        <= {r_shadow[119:0], bus.rx_byte};
        r_key_loaded <= 1'b1;
      end

      if (w_capture)       r_result <= bus.core_result;
      else if (w_tx_shift) r_result <= {r_result[119:0], 8'h00};

      if (w_capture)                   r_result_ready <= 1'b1;
      else if (w_launch || w_tx_last)  r_result_ready <= 1'b0;
    end
  end

  assign bus.text_out     = r_text;
  assign bus.key_out      = r_key;
  assign bus.core_start   = r_core_start;
  assign bus.tx_valid     = w_tx_valid;
  assign bus.tx_byte      = w_tx_valid ? r_result[127:120] : 8'h00;
  assign bus.text_loaded  = r_text_loaded;
  assign bus.key_loaded   = r_key_loaded;
  assign bus.result_ready = r_result_ready;
  assign bus.err          = r_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_aes_frame_assembler.sv
// Randomized self-checking bench for aes_frame_assembler against a frame-level model.
// Define FRAME_TIMEOUT_EN to also exercise the inter-byte timeout (8-cycle limit).
module tb_aes_frame_assembler;

  localparam logic [7:0] CMD_TEXT  = 8'h01;
  localparam logic [7:0] CMD_KEY   = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_READ  = 8'h04;
  localparam logic [2:0] IDLE_CODE = 3'd0;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  aes_frame_assembler_if bus_if ();

`ifdef FRAME_TIMEOUT_EN
  aes_frame_assembler #(.TIMEOUT_CYCLES(8)) dut (
`else
  aes_frame_assembler dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // frame-level model of what the block should hold
  logic [127:0] m_text, m_key, m_result;
  bit           m_text_ld, m_key_ld, m_ready;
  logic [7:0]   exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_byte  = b;
    tick();
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic model_clear();
    m_text = '0; m_key = '0; m_result = '0;
    m_text_ld = 0; m_key_ld = 0; m_ready = 0;
    exp_q.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_text"},  bus_if.text_out, '0);
    check({tag, "_key"},   bus_if.key_out, '0);
    check({tag, "_flags"}, {bus_if.text_loaded, bus_if.key_loaded, bus_if.result_ready,
                            bus_if.err, bus_if.core_start, bus_if.tx_valid}, '0);
    check({tag, "_txbyte"}, bus_if.tx_byte, '0);
    check({tag, "_state"},  dbg_state, IDLE_CODE);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_text_out"},     bus_if.text_out, m_text);
    check({tag, "_key_out"},      bus_if.key_out, m_key);
    check({tag, "_text_loaded"},  bus_if.text_loaded, m_text_ld);
    check({tag, "_key_loaded"},   bus_if.key_loaded, m_key_ld);
    check({tag, "_result_ready"}, bus_if.result_ready, m_ready);
    check({tag, "_state"},        dbg_state, IDLE_CODE);
  endtask

  // payload byte i travels as bits [127-8i -: 8]
  task automatic load_frame(input bit is_key, input logic [127:0] payload);
    send_byte(is_key ? CMD_KEY : CMD_TEXT);
    check("load_type_err", bus_if.err, 0);
    for (int i = 0; i < 16; i++) begin
      gap($urandom_range(0, 2));
      send_byte(payload[127-8*i -: 8]);
      if (i == 7) begin
        check("no_partial_text", bus_if.text_out, m_text);
        check("no_partial_key",  bus_if.key_out, m_key);
      end
    end
    if (is_key) begin m_key = payload;  m_key_ld = 1; end
    else        begin m_text = payload; m_text_ld = 1; end
    check_held("load");
  endtask

  task automatic bad_cmd(input logic [7:0] b, input string tag);
    send_byte(b);
    check({tag, "_err"}, bus_if.err, 1);
    check({tag, "_state"}, dbg_state, IDLE_CODE);
    tick();
    check({tag, "_err_pulse"}, bus_if.err, 0);
  endtask

  task automatic run_core(input logic [127:0] res, input bit with_rx);
    int k;
    k = $urandom_range(1, 4);
    bus_if.core_busy = 1'b1;
    for (int i = 0; i < k; i++) begin
      tick();
      check("start_pulse_width", bus_if.core_start, 0);
      check("ready_while_busy", bus_if.result_ready, 0);
    end
    bus_if.core_busy   = 1'b0;
    bus_if.core_done   = 1'b1;
    bus_if.core_result = res;
    if (with_rx) begin
      bus_if.rx_valid = 1'b1;
      bus_if.rx_byte  = 8'($urandom);
    end
    tick();
    bus_if.core_done = 1'b0;
    bus_if.rx_valid  = 1'b0;
    m_result = res;
    m_ready  = 1;
    check("done_ready", bus_if.result_ready, 1);
    check("done_rx_err", bus_if.err, with_rx);
    check("done_state", dbg_state, IDLE_CODE);
    tick();
    check("done_err_clear", bus_if.err, 0);
  endtask

  task automatic do_start(input logic [127:0] res, input bit with_rx);
    bit ok;
    int waited;
    ok = m_text_ld && m_key_ld;
    send_byte(CMD_START);
    check("start_err", bus_if.err, !ok);
    if (!ok) begin
      check("start_state", dbg_state, IDLE_CODE);
      for (int i = 0; i < 3; i++) begin
        tick();
        check("no_core_start", bus_if.core_start, 0);
      end
    end else begin
      waited = 0;
      while (!bus_if.core_start && waited < 20) begin
        tick();
        waited++;
      end
      check("start_latency", waited, 1);
      if (bus_if.core_start) begin
        m_ready = 0;
        check("launch_clears_ready", bus_if.result_ready, 0);
        run_core(res, with_rx);
      end
    end
  endtask

  task automatic do_read();
    int cycles;
    int got;
    logic [7:0] exp_b;
    send_byte(CMD_READ);
    check("read_err", bus_if.err, !m_ready);
    if (!m_ready) begin
      check("read_state", dbg_state, IDLE_CODE);
    end else begin
      for (int i = 0; i < 16; i++) exp_q.push_back(m_result[127-8*i -: 8]);
      cycles = 0;
      got    = 0;
      while (got < 16 && cycles < 200) begin
        bus_if.tx_ready = ($urandom_range(0, 3) != 0);
        bus_if.rx_valid = 1'($urandom_range(0, 1));
        bus_if.rx_byte  = 8'($urandom);
        check("tx_valid", bus_if.tx_valid, 1);
        check("ready_during_tx", bus_if.result_ready, 1);
        if (bus_if.tx_ready && exp_q.size() > 0) begin
          exp_b = exp_q.pop_front();
          check("tx_byte", bus_if.tx_byte, exp_b);
          got++;
        end
        tick();
        cycles++;
        check("tx_dummy_err", bus_if.err, 0);
      end
      bus_if.tx_ready = 1'b0;
      bus_if.rx_valid = 1'b0;
      check("tx_count", got, 16);
      m_ready = 0;
      exp_q.delete();
      check("tx_valid_end", bus_if.tx_valid, 0);
      check_held("read_end");
    end
  endtask

  logic [127:0] rnd;
  logic [127:0] kp;
  logic [7:0]   b;

  initial begin
    bus_if.rx_valid    = 1'b0;
    bus_if.rx_byte     = 8'h00;
    bus_if.core_busy   = 1'b0;
    bus_if.core_done   = 1'b0;
    bus_if.core_result = '0;
    bus_if.tx_ready    = 1'b0;
    reset = 1'b0;
    model_clear();

    gap(3);
    check_zero_outputs("reset");
    reset = 1'b1;
    tick();

    // key 00..0f, text from the reference vector
    for (int i = 0; i < 16; i++) kp[127-8*i -: 8] = 8'(i);
    load_frame(1'b1, kp);
    check("key_vector", bus_if.key_out, 128'h000102030405060708090a0b0c0d0e0f);
    check("text_not_loaded", bus_if.text_loaded, 0);

    do_start(128'h0, 1'b0);
    do_read();
    bad_cmd(8'h7e, "bad_type");

    load_frame(1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("text_vector", bus_if.text_out, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    do_start(128'h00112233445566778899aabbccddeeff, 1'b0);
    do_read();

    // core busy for 5 cycles when the start command lands
    bus_if.core_busy = 1'b1;
    send_byte(CMD_START);
    check("busy_start_err", bus_if.err, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("busy_no_start", bus_if.core_start, 0);
    end
    bus_if.core_busy = 1'b0;
    tick();
    check("busy_start_once", bus_if.core_start, 1);
    m_ready = 0;
    run_core(128'hfedcba98765432100123456789abcdef, 1'b1);
    do_read();

    // randomized command mix
    for (int it = 0; it < 40; it++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 4))
        0: load_frame(1'b0, rnd);
        1: load_frame(1'b1, rnd);
        2: do_start(rnd, 1'($urandom_range(0, 1)));
        3: do_read();
        default: begin
          b = 8'($urandom_range(5, 255));
          bad_cmd(b, "rand_bad_type");
        end
      endcase
      gap($urandom_range(0, 3));
    end

    // reset in the middle of a text frame
    send_byte(CMD_TEXT);
    for (int i = 0; i < 7; i++) send_byte(8'($urandom));
    reset = 1'b0;
    #2;
    model_clear();
    check_zero_outputs("midframe_reset");
    tick();
    reset = 1'b1;
    tick();
    load_frame(1'b0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);

`ifdef FRAME_TIMEOUT_EN
    send_byte(CMD_TEXT);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    for (int i = 0; i < 7; i++) begin
      tick();
      check("timeout_early", bus_if.err, 0);
    end
    tick();
    check("timeout_err", bus_if.err, 1);
    check_held("timeout");
    load_frame(1'b0, 128'hdeadbeef00112233cafef00d44556677);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_frame_assembler.md
Name: aes_frame_assembler

Overview:
- Sits between the SPI slave byte interface and the AES decryption core.
- Parses the byte stream sent by the SPI master: a command (type) byte, then 16 payload bytes for text or key.
- Assembles the 128-bit ciphertext and key, launches the core, captures the 128-bit result and streams it back byte-wise for MISO transmission.

Parameters:
- CMD_TEXT, 8'h01, type byte announcing 16 ciphertext bytes
- CMD_KEY, 8'h02, type byte announcing 16 key bytes
- CMD_START, 8'h03, type byte launching decryption
- CMD_READ, 8'h04, type byte requesting result readback
- TIMEOUT_CYCLES, 1024, inter-byte timeout in clk cycles (used only with FRAME_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_byte holds a newly received SPI byte
- rx_byte  in  8  received byte
- text_out  out  128  assembled ciphertext to core
- key_out  out  128  assembled key to core
- core_start  out  1  one-cycle launch pulse to core
- core_busy  in  1  core is processing
- core_done  in  1  one-cycle strobe: core_result valid
- core_result  in  128  decrypted block
- tx_valid  out  1  tx_byte valid for SPI slave
- tx_byte  out  8  result byte to transmit
- tx_ready  in  1  SPI slave accepts tx_byte this cycle
- text_loaded  out  1  complete text frame held
- key_loaded  out  1  complete key frame held
- result_ready  out  1  result captured, not yet read out
- err  out  1  one-cycle error pulse

Behaviour:
- Reset (reset=0, async): state=IDLE; byte counter=0; shadow, text_out, key_out, result register=0; all flags and strobes=0; tx_byte=0. A reset mid-frame discards all partial data.
- Byte order: MSB first. The first payload byte lands in [127:120]. The shadow register shifts as shadow <= {shadow[119:0], rx_byte}.
- Counter: 4-bit, 0..15. It advances only on an accepted byte and returns to 0 on frame completion or abort.
- IDLE, on rx_valid, decodes the type byte:
  - CMD_TEXT -> RX_TEXT.
  - CMD_KEY -> RX_KEY.
  - CMD_START -> LAUNCH if text_loaded && key_loaded; else err pulse and stay in IDLE.
  - CMD_READ -> TX_RESULT if result_ready; else err pulse.
  - Any other value -> err pulse and stay in IDLE.
- RX_TEXT / RX_KEY:
  - Each rx_valid shifts one byte into the shadow register.
  - On the 16th byte (counter==15), in the same edge: text_out or key_out <= {shadow[119:0], rx_byte}; the matching *_loaded flag is set; state -> IDLE.
  - text_out/key_out never show partial frames.
  - Reloading a frame overwrites it; result_ready is unaffected.
- LAUNCH:
  - If core_busy=0: core_start=1 for exactly one cycle, result_ready cleared, state -> WAIT_CORE.
  - Otherwise hold in LAUNCH with no pulse.
- WAIT_CORE:
  - On core_done: result register <= core_result, result_ready=1, state -> IDLE.
  - rx_valid in this state: byte dropped, err pulse.
- TX_RESULT:
  - tx_valid=1 and tx_byte = result register[127:120].
  - On tx_valid && tx_ready: shift the result register left 8 and increment the counter.
  - After the 16th accepted byte: tx_valid=0, result_ready=0, state -> IDLE.
  - rx_valid during TX_RESULT is ignored with no err; these are the dummy bytes clocked by the master.
- Simultaneous events:
  - core_done in the same cycle as rx_valid in WAIT_CORE: the result is captured and the byte is dropped with err.
  - core_done outside WAIT_CORE: ignored.
- Latencies:
  - Type byte -> state change: 1 cycle.
  - 16th payload byte -> *_loaded high: next cycle.
  - CMD_START with core idle -> core_start on the following cycle.
  - core_done -> result_ready: 1 cycle.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- With the macro: a timer counts clk cycles without rx_valid while in RX_TEXT/RX_KEY.
  - Reaching TIMEOUT_CYCLES aborts the frame: shadow discarded, counter=0, err pulse, state -> IDLE.
  - The previously committed text_out/key_out and *_loaded flags are retained.
  - The timer resets on every accepted byte.
- Without the macro: no timer logic; RX states wait indefinitely.

Test Plan:
- Key load: send 02, 00,01,...,0f -> key_out=000102030405060708090a0b0c0d0e0f; key_loaded=1 the cycle after the last byte; text_loaded=0.
- Text load: send 01 then 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a -> text_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Full flow: key, text, 03, core returns 00112233445566778899aabbccddeeff, then 04 with tx_ready=1 -> tx_byte sequence 00,11,...,ff; result_ready falls after the 16th byte.
- Errors: 03 with only the key loaded -> err pulse, no core_start; 04 with no result -> err; type byte 7e -> err; state stays IDLE.
- Busy core: 03 while core_busy=1 for 5 cycles -> core_start is issued exactly once, one cycle after core_busy falls.
- Reset mid-frame: reset low after 7 text bytes -> all outputs 0. A subsequent full text frame loads correctly. With FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=8: stall 8 cycles after 3 bytes -> err pulse, text_loaded unchanged.
